// File: rtl/call_n.sv
// call_n: round-robin arbiter joining N four-phase client channels onto one server channel.
// The chosen client's data word is captured at grant, and any protocol violation sets a sticky flag.
module call_n #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   r_i,
   output logic [N-1:0]   d_o,
   input  logic [N*W-1:0] data_i,
   output logic           r,
   input  logic           d,
   output logic [W-1:0]   data_o,
   output logic [SW-1:0]  sel,
   output logic           busy,
   output logic           err
);
   typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d, sel_q, sel_d, pick;
   logic [W-1:0] data_q, data_d;
   logic [N-1:0] d_o_q, d_o_d;
   logic r_q, r_d, err_q, err_d, busy_q, busy_d;
   int j;
   always_comb begin
      pick = '0;
      j = 0;
      // Scan from the highest offset down so the first requester at or after ptr wins
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (r_i[j]) pick = SW'(j);
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      sel_d = sel_q;
      data_d = data_q;
      r_d = r_q;
      d_o_d = d_o_q;
      err_d = err_q;
      case (state_q)
         IDLE: begin
            err_d = err_q | d;
            if (|r_i) begin
               sel_d = pick;
               data_d = data_i[int'(pick)*W +: W];
               r_d = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            err_d = err_q | ~r_i[sel_q];
            if (d) begin
               d_o_d = N'(1) << sel_q;
               state_d = ACK;
            end
         end
         ACK: begin
            err_d = err_q | ~d;
            if (!r_i[sel_q]) begin
               r_d = 1'b0;
               state_d = RTZ;
            end
         end
         default: begin
            if (!d) begin
               d_o_d = '0;
               ptr_d = (int'(sel_q) == N - 1) ? '0 : sel_q + SW'(1);
               state_d = IDLE;
            end
         end
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         sel_q <= '0;
         data_q <= '0;
         r_q <= 1'b0;
         d_o_q <= '0;
         err_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         sel_q <= sel_d;
         data_q <= data_d;
         r_q <= r_d;
         d_o_q <= d_o_d;
         err_q <= err_d;
         busy_q <= busy_d;
      end
   end
   assign r = r_q;
   assign d_o = d_o_q;
   assign data_o = data_q;
   assign sel = sel_q;
   assign busy = busy_q;
   assign err = err_q;
endmodule

// File: tb/tb_call_n.sv
// tb_call_n: directed checks of call_n with four 8-bit clients.
module tb_call_n;
   logic clk = 0, rst = 1, d = 0, r, busy, err;
   logic [3:0] r_i = 0, d_o;
   logic [31:0] data_i = 0;
   logic [7:0] data_o;
   logic [1:0] sel;
   int n_cmp = 0, n_bad = 0;

   call_n #(.N(4), .W(8)) dut (
      .clk(clk), .rst(rst), .r_i(r_i), .d_o(d_o), .data_i(data_i),
      .r(r), .d(d), .data_o(data_o), .sel(sel), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r_i = 0; d = 0; rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL reset_r got %0b want 0", r); end
      n_cmp++; if (d_o !== 4'b0) begin n_bad++; $display("FAIL reset_d_o got %b want 0000", d_o); end
      n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_o); end
      n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
   endtask

   task automatic test_single();
      do_reset();
      data_i[2*8 +: 8] = 8'hA5;
      r_i = 4'b0100;
      step();
      n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL single_r_rise got %0b want 1", r); end
      n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel got %0d want 2", sel); end
      n_cmp++; if (data_o !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", data_o); end
      n_cmp++; if (d_o !== 4'b0000) begin n_bad++; $display("FAIL single_d_o_req got %b want 0000", d_o); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %0b want 1", busy); end
      d = 1;
      step();
      n_cmp++; if (d_o !== 4'b0100) begin n_bad++; $display("FAIL single_d_o_ack got %b want 0100", d_o); end
      r_i = 0;
      step();
      n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL single_r_fall got %0b want 0", r); end
      n_cmp++; if (d_o !== 4'b0100) begin n_bad++; $display("FAIL single_d_o_rtz got %b want 0100", d_o); end
      d = 0;
      step();
      n_cmp++; if (d_o !== 4'b0000) begin n_bad++; $display("FAIL single_d_o_fall got %b want 0000", d_o); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall got %0b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %0b want 0", err); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      data_i = 32'h44332211;
      r_i = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         step();
         n_cmp++; if (sel !== exp_sel[t]) begin n_bad++; $display("FAIL rr_sel[%0d] got %0d want %0d", t, sel, exp_sel[t]); end
         n_cmp++; if (data_o !== 8'(8'h11 * (exp_sel[t] + 1))) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", t, data_o, 8'(8'h11 * (exp_sel[t] + 1))); end
         d = 1;
         step();
         r_i[exp_sel[t]] = 1'b0;
         step();
         d = 0;
         r_i = 4'b1111;
         step();
      end
      r_i = 0;
      step();
   endtask

   task automatic test_isolation();
      do_reset();
      data_i = 32'h33000000 | 32'h00001100;
      r_i = 4'b0010;
      step();
      d = 1;
      step();
      r_i = 4'b1010;
      step();
      n_cmp++; if (d_o !== 4'b0010) begin n_bad++; $display("FAIL iso_d_o_ack got %b want 0010", d_o); end
      n_cmp++; if (data_o !== 8'h11) begin n_bad++; $display("FAIL iso_data got %h want 11", data_o); end
      n_cmp++; if (sel !== 2'd1) begin n_bad++; $display("FAIL iso_sel got %0d want 1", sel); end
      r_i = 4'b1000;
      step();
      n_cmp++; if (d_o !== 4'b0010) begin n_bad++; $display("FAIL iso_d_o_rtz got %b want 0010", d_o); end
      d = 0;
      step();
      n_cmp++; if (r !== 1'b0 || d_o !== 4'b0) begin n_bad++; $display("FAIL iso_idle got r=%0b d_o=%b want r=0 d_o=0000", r, d_o); end
      step();
      n_cmp++; if (sel !== 2'd3) begin n_bad++; $display("FAIL iso_next_sel got %0d want 3", sel); end
      n_cmp++; if (data_o !== 8'h33) begin n_bad++; $display("FAIL iso_next_data got %h want 33", data_o); end
      n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL iso_next_r got %0b want 1", r); end
      d = 1;
      step();
      n_cmp++; if (d_o !== 4'b1000) begin n_bad++; $display("FAIL iso_next_d_o got %b want 1000", d_o); end
      r_i = 0;
      step();
      d = 0;
      step();
      n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL iso_end got busy=%0b err=%0b want 0 0", busy, err); end
   endtask

   task automatic test_err_idle();
      do_reset();
      d = 1;
      step();
      d = 0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle got %0b want 1", err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_idle_busy got %0b want 0", busy); end
      step();
      step();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_sticky got %0b want 1", err); end
   endtask

   task automatic test_err_req();
      do_reset();
      r_i = 4'b0001;
      step();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_req_pre got %0b want 0", err); end
      r_i = 0;
      step();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_req got %0b want 1", err); end
      n_cmp++; if (r !== 1'b1 || d_o !== 4'b0) begin n_bad++; $display("FAIL err_req_hold got r=%0b d_o=%b want r=1 d_o=0000", r, d_o); end
      d = 1;
      step();
      step();
      d = 0;
      step();
      n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL err_req_end got busy=%0b err=%0b want 0 1", busy, err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      data_i = 32'hD4C3B2A1;
      r_i = 4'b0010;
      step();
      d = 1;
      step();
      r_i = 0;
      step();
      d = 0;
      step();
      r_i = 4'b0100;
      step();
      d = 1;
      step();
      n_cmp++; if (d_o !== 4'b0100) begin n_bad++; $display("FAIL rmid_pre got %b want 0100", d_o); end
      rst = 1;
      #1;
      n_cmp++; if (r !== 1'b0 || d_o !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_async got r=%0b d_o=%b busy=%0b want 0", r, d_o, busy); end
      n_cmp++; if (sel !== 2'd0 || data_o !== 8'h00 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_async_data got sel=%0d data=%h err=%0b want 0", sel, data_o, err); end
      d = 0;
      r_i = 4'b1001;
      #2;
      rst = 0;
      step();
      n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL rmid_ptr got %0d want 0", sel); end
      n_cmp++; if (data_o !== 8'hA1 || r !== 1'b1) begin n_bad++; $display("FAIL rmid_grant got data=%h r=%0b want a1 1", data_o, r); end
      d = 1;
      step();
      n_cmp++; if (d_o !== 4'b0001) begin n_bad++; $display("FAIL rmid_ack got %b want 0001", d_o); end
      r_i = 0;
      step();
      d = 0;
      step();
   endtask

   task automatic test_data_hold();
      do_reset();
      data_i = 32'h0000005A;
      r_i = 4'b0001;
      step();
      n_cmp++; if (data_o !== 8'h5A) begin n_bad++; $display("FAIL hold_grant got %h want 5a", data_o); end
      data_i[7:0] = 8'hFF;
      step();
      n_cmp++; if (data_o !== 8'h5A) begin n_bad++; $display("FAIL hold_req got %h want 5a", data_o); end
      d = 1;
      step();
      data_i[7:0] = 8'h00;
      step();
      n_cmp++; if (data_o !== 8'h5A) begin n_bad++; $display("FAIL hold_ack got %h want 5a", data_o); end
      r_i = 0;
      step();
      d = 0;
      step();
      n_cmp++; if (data_o !== 8'h5A || busy !== 1'b0) begin n_bad++; $display("FAIL hold_end got data=%h busy=%0b want 5a 0", data_o, busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_isolation();
      test_err_idle();
      test_err_req();
      test_reset_mid();
      test_data_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/call_n.md
# call_n

Parametrised, clocked successor to our two-way call element: arbitrates N four-phase (return-to-zero) client channels onto one shared server channel. Handles simultaneous requests with a round-robin choice, forwards the granted client's data word to the server, and routes the server acknowledge back to the granted client only. It sits between multiple initiators and a single shared handshake resource in synchronous islands of the async library, and adds sticky protocol-violation detection.

## Interface
- N, default 4: number of client channels; legal values are 2 and above.
- W, default 8: width of the data word per client.
- SW, default clog2(N): width of the select index. Derived, not overridable.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- r_i  input  N  client requests; bit k belongs to client k.
- d_o  output  N  client acknowledges; one-hot or zero.
- data_i  input  N*W  client data; client k occupies bits [k*W +: W].
- r  output  1  server request.
- d  input  1  server acknowledge.
- data_o  output  W  data of the granted client, held for the whole transaction.
- sel  output  SW  index of the granted or last-granted client.
- busy  output  1  high whenever the FSM is not in IDLE.
- err  output  1  sticky protocol-violation flag.

## Operation
- All outputs are registered.
- Reset values: r=0, d_o=0, data_o=0, sel=0, busy=0, err=0, state=IDLE, round-robin pointer ptr=0.
- FSM states: IDLE, REQ, ACK, RTZ.
  - **IDLE**: if r_i is nonzero, pick the first set bit searching ptr, ptr+1, … with wrap modulo N. Load sel with that index and data_o with that client's data word. Set r=1 and go to REQ. If r_i is zero, stay in IDLE.
  - **REQ**: hold r=1. When d=1, set d_o[sel]=1 and go to ACK.
  - **ACK**: hold r=1 and d_o[sel]=1. When r_i[sel]=0, set r=0 and go to RTZ.
  - **RTZ**: hold d_o[sel]=1. When d=0, set d_o=0, set ptr to (sel+1) mod N, and go to IDLE.
- Requests from clients other than sel are ignored during a transaction. They stay pending and compete at the next IDLE.
- data_i is sampled only on the IDLE-to-REQ edge. Later changes on data_i do not affect data_o.
- err is set (and remains set until rst) on any of these conditions:
  - d=1 while in IDLE;
  - r_i[sel]=0 while in REQ (client withdrew before acknowledge);
  - d=0 while in ACK.
- An error does not alter the state transitions. The FSM keeps waiting for the legal event.
- rst asserted mid-transaction returns every output and the pointer to the reset values immediately. It does not wait for the clock.

## Timing
- Each FSM step takes exactly one rising edge after the enabling input is sampled high or low.
- r rises 1 cycle after r_i[k] is first sampled high in IDLE.
- d_o[sel] rises 1 cycle after d is sampled high.
- r falls 1 cycle after r_i[sel] is sampled low.
- d_o[sel] falls 1 cycle after d is sampled low.
- With a zero-latency server and client, a transaction occupies 4 cycles.
- The next grant can occur on the edge immediately after the return to IDLE, so a back-to-back transaction adds no idle gap beyond the IDLE cycle itself.
- sel and data_o are stable from the IDLE-to-REQ edge until the next grant.
- Inputs are assumed synchronous to clk. Synchronisers are outside this block.

## Test plan
- **Single request.** Client 2 raises r_i with data 0xA5. Required response:
  - r=1 after 1 cycle, with sel=2 and data_o=0xA5.
  - The server raises d; d_o=0b0100 after 1 cycle.
  - The full four-phase sequence completes, busy falls, and err stays 0.
- **Round robin.** All four r_i bits held high continuously with ptr=0. Grants must occur in order sel=0, 1, 2, 3, 0. No client is granted twice before every other pending client has been granted once.
- **Isolation.** Client 1 is in ACK and client 3 raises r_i. Required response: d_o[3] stays 0, data_o stays unchanged, and client 3 is granted on the first IDLE after client 1 completes.
- **Protocol errors.** Two cases, each starting from a clean reset:
  - Pulse d for 1 cycle in IDLE: err=1 on the next cycle and remains 1.
  - Drop r_i[sel] in REQ: err=1.
- **Reset mid-transaction.** Assert rst while in ACK. All outputs must be 0 immediately (asynchronously). After rst is released, a new request from client 0 is granted normally and ptr restarts at 0.
- **Data hold.** Change data_i[sel] during REQ and ACK. data_o must keep the value sampled at grant.
